rx_matched_filter: RTL and testbench
====================================

Name: rx_matched_filter

Overview:
- Receive-side matched filter paired with the 21-tap symmetric tx pulse-shaping filter.
- Takes 18-bit 1s17 samples at the oversampled rate, filters them with the same coefficient set, and decimates to symbol rate. Samples arrive with a valid strobe.
- A single multiplier is time-shared across the 11 unique taps, so each output is computed serially by a small state machine.
- Sits between the channel/ADC sample stream and the symbol slicer.

Parameters:
- DECIM, 4, decimation factor; one output per DECIM accepted samples.
- PHASE_W, 2, width of phase_sel; must satisfy 2^PHASE_W >= DECIM.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- x_in  in  18  signed 1s17 input sample.
- in_valid  in  1  x_in valid this cycle.
- phase_sel  in  PHASE_W  decimation phase; trigger when sample count mod DECIM == phase_sel.
- y  out  18  signed 1s17 filtered symbol-rate output.
- y_valid  out  1  one-cycle pulse when y updates.
- busy  out  1  high while an output computation is in progress.
- overrun  out  1  sticky; set when a trigger arrives while busy.

Behaviour:
- Reset (reset=0, async) clears the following immediately:
  - delay line x[0..20], snapshot, accumulator, tap index and sample counter to 0;
  - state to IDLE;
  - y, y_valid, busy and overrun to 0.
- Delay line:
  - On each in_valid edge: x[0]<=x_in, x[k]<=x[k-1] for k=1..20.
  - Shifting continues regardless of state.
- Sample counter:
  - Counts accepted samples mod DECIM; the first sample after reset is count 0.
  - Trigger = in_valid && (count == phase_sel), using the count value before increment.
- Coefficients (1s17, fixed): b[0..10] = 1098, 2004, 1369, -1660, -5845, -7567, -2655, 10462, 28563, 44456, 50787.
- Pre-add: p[i] = x[i]+x[20-i] for i=0..9, and p[10] = x[10]; each is 19 bits signed, with no overflow.
- State machine (edge 0 = trigger edge):
  - IDLE: on trigger -> LOAD; busy=1 from edge 0.
  - LOAD (edge 1): snapshot p[0..10] from the already-shifted delay line; acc=0; idx=0; -> MAC.
  - MAC (edges 2..12): acc += p[idx]*b[idx]; idx++; after idx=10 -> DONE.
  - DONE (edge 13): register y and pulse y_valid for one cycle; -> IDLE; busy=0 after edge 13.
- Latency: y_valid is high in the cycle after edge 13, i.e. 13 clocks after the trigger edge. The computation uses the window containing the trigger sample as x[0].
- Later samples shifting in during LOAD/MAC do not affect the result, because the snapshot is isolated from the delay line.
- Arithmetic:
  - Product is 37-bit signed.
  - acc is 41-bit signed.
  - Rounded result r = (acc + 2^16) >>> 17 (round half up).
  - y = r reduced to 18 bits as specified under Optional Feature.
- Trigger while busy: the trigger is dropped and overrun is set, staying set until reset. The in-progress computation is unaffected.
- With in_valid spacing >= 4 clocks and DECIM=4, overrun never sets.
- y holds its value between y_valid pulses.
- phase_sel may change at any time; it takes effect at the next trigger evaluation.

Optional Feature:
- Macro: RX_MF_SAT_EN.
- Defined: r is saturated to [-131072, 131071].
- Undefined: y = r[17:0] (two's-complement wrap).

Test Plan:
- Reset mid-MAC: assert reset=0 during MAC -> y=0, y_valid=0, busy=0 and overrun=0 immediately. After release, the first trigger is at sample count == phase_sel.
- Impulse, phase_sel=0, one in_valid every 4 clocks: sample 2 = 65536, all others 0. Expected y sequence at samples 4, 8, 12, 16, 20, 24 is 685, -1327, 25394, -1327, 685, 0.
- Latency/handshake: on trigger at edge T -> busy high from T, y_valid high for exactly one cycle after edge T+13, and busy low after edge T+13.
- DC 65536 on every sample (spacing 4), after >= 21 samples -> y = 95619 on every y_valid.
- DC 131071 -> y = 131071 with RX_MF_SAT_EN, or y = -70908 without it.
- Overrun: in_valid every clock with DECIM=4 (trigger every 4 clocks, computation 14 clocks) -> overrun sets on the second trigger and stays set; the first y_valid still appears at T+13 with the correct value.

Source files
------------

// File: rtl/rx_matched_filter.sv
// Receive matched filter: 21-tap symmetric FIR with one time-shared multiplier, decimating by DECIM.
// Optional macro RX_MF_SAT_EN saturates the rounded output; otherwise it wraps to 18 bits.
module rx_matched_filter #(
  parameter int unsigned DECIM   = 4,
  parameter int unsigned PHASE_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [17:0]        x_in,
  input  logic                      in_valid,
  input  logic        [PHASE_W-1:0] phase_sel,
  output logic signed [17:0]        y,
  output logic                      y_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned DW       = 18;
  localparam int unsigned PW       = 19;
  localparam int unsigned CW       = 18;
  localparam int unsigned MW       = 37;
  localparam int unsigned AW       = 41;
  localparam int unsigned NTAP     = 21;
  localparam int unsigned NUNIQ    = 11;
  localparam int unsigned IW       = 4;
  localparam int unsigned RND_SH   = 17;
  localparam int unsigned RW       = AW - RND_SH;

  localparam logic [IW-1:0]          LAST_IDX = IW'(NUNIQ - 1);
  localparam logic [PHASE_W-1:0]     CNT_LAST = PHASE_W'(DECIM - 1);
  localparam logic signed [AW-1:0]   RND_HALF = AW'(1 << (RND_SH - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0]   dly [NTAP];
  logic signed [PW-1:0]   pre [NUNIQ];
  logic signed [PW-1:0]   snap [NUNIQ];
  logic signed [AW-1:0]   acc_q;
  logic        [IW-1:0]   idx_q;
  logic        [PHASE_W-1:0] cnt_q;

  logic                   trigger;
  logic signed [CW-1:0]   coef_cur;
  logic signed [MW-1:0]   prod;
  logic signed [DW-1:0]   y_next;

  // Unique half of the symmetric coefficient set, 1s17.
  function automatic logic signed [CW-1:0] coef(input logic [IW-1:0] i);
    case (i)
      4'd0:    coef = 18'sd1098;
      4'd1:    coef = 18'sd2004;
      4'd2:    coef = 18'sd1369;
      4'd3:    coef = -18'sd1660;
      4'd4:    coef = -18'sd5845;
      4'd5:    coef = -18'sd7567;
      4'd6:    coef = -18'sd2655;
      4'd7:    coef = 18'sd10462;
      4'd8:    coef = 18'sd28563;
      4'd9:    coef = 18'sd44456;
      4'd10:   coef = 18'sd50787;
      default: coef = '0;
    endcase
  endfunction

  // Sample delay line keeps shifting even while a computation is running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAP; k++) dly[k] <= '0;
    end else if (in_valid) begin
      dly[0] <= x_in;
      for (int k = 1; k < NTAP; k++) dly[k] <= dly[k-1];
    end
  end

  // Accepted-sample counter modulo DECIM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (in_valid) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + PHASE_W'(1);
    end
  end

  assign trigger = in_valid && (cnt_q == phase_sel);

  // Symmetric pre-add; centre tap passes through sign-extended.
  always_comb begin
    for (int i = 0; i < NUNIQ - 1; i++) begin
      pre[i] = $signed({dly[i][DW-1], dly[i]}) + $signed({dly[NTAP-1-i][DW-1], dly[NTAP-1-i]});
    end
    pre[NUNIQ-1] = $signed({dly[NUNIQ-1][DW-1], dly[NUNIQ-1]});
  end

  assign coef_cur = coef(idx_q);
  assign prod = $signed({{(MW-PW){snap[0][PW-1]}}, snap[0]})
              * $signed({{(MW-CW){coef_cur[CW-1]}}, coef_cur});

`ifdef RX_MF_SAT_EN
  logic signed [RW-1:0] r_full;

  always_comb begin
    r_full = RW'((acc_q + RND_HALF) >>> RND_SH);
    if ((r_full[RW-1:DW-1] == '0) || (r_full[RW-1:DW-1] == '1)) begin
      y_next = r_full[DW-1:0];
    end else if (r_full[RW-1]) begin
      y_next = {1'b1, {(DW-1){1'b0}}};
    end else begin
      y_next = {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  always_comb begin
    y_next = DW'((acc_q + RND_HALF) >>> RND_SH);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trigger) state_d = S_LOAD;
      S_LOAD:  state_d = S_MAC;
      S_MAC:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Snapshot is a shift register so the MAC always reads its head entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUNIQ; i++) snap[i] <= '0;
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          for (int i = 0; i < NUNIQ; i++) snap[i] <= pre[i];
          acc_q <= '0;
          idx_q <= '0;
        end
        S_MAC: begin
          for (int i = 0; i < NUNIQ - 1; i++) snap[i] <= snap[i+1];
          snap[NUNIQ-1] <= '0;
          acc_q <= acc_q + $signed({{(AW-MW){prod[MW-1]}}, prod});
          idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y       <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= (state_q == S_DONE);
      busy    <= (state_d != S_IDLE);
      if (state_q == S_DONE) y <= y_next;
      if (trigger && (state_q != S_IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_matched_filter.sv
// Directed bench for rx_matched_filter: reset, latency, impulse, DC, overrun and phase selection.
module tb_rx_matched_filter;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [17:0] x_in;
  logic               in_valid;
  logic [1:0]         phase_sel;
  logic signed [17:0] y;
  logic               y_valid;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;
  int cap_q[$];

`ifdef RX_MF_SAT_EN
  localparam int DC_MAX_Y = 131071;
`else
  localparam int DC_MAX_Y = -70908;
`endif

  rx_matched_filter #(.DECIM(4), .PHASE_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .phase_sel (phase_sel),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (y_valid === 1'b1) cap_q.push_back(int'(y));
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted sample followed by three idle clocks; reports busy just after the sample edge.
  task automatic send(input logic signed [17:0] v, output logic b);
    x_in = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    b = busy;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  function automatic int cap_at(input int i);
    return (i < cap_q.size()) ? cap_q[i] : 32'h7fff_ffff;
  endfunction

  initial begin
    logic b;
    int   lat_bad;
    int   exp_imp [7];

    exp_imp = '{0, 685, -1327, 25394, -1327, 685, 0};
    reset = 1'b0; x_in = '0; in_valid = 1'b0; phase_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;

    // Latency on the very first trigger (sample 0), then the impulse response.
    cap_q.delete();
    x_in = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_busy_t0", busy, 1);
    chk("lat_yv_t0", y_valid, 0);
    lat_bad = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || y_valid !== 1'b0) lat_bad++;
    end
    chk("lat_mid", lat_bad, 0);
    @(posedge clk); #1;
    chk("lat_yv_t13", y_valid, 1);
    chk("lat_busy_t13", busy, 0);
    @(posedge clk); #1;
    chk("lat_yv_t14", y_valid, 0);
    for (int s = 1; s <= 24; s++) send((s == 2) ? 18'sd65536 : 18'sd0, b);
    repeat (16) begin @(posedge clk); #1; end
    chk("imp_count", cap_q.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("imp_y%0d", i), cap_at(i), exp_imp[i]);

    // DC 65536 with phase 1; last three outputs see a full window.
    do_reset();
    phase_sel = 2'd1;
    cap_q.delete();
    for (int s = 0; s < 32; s++) send(18'sd65536, b);
    repeat (16) begin @(posedge clk); #1; end
    chk("dc_count", cap_q.size(), 8);
    for (int i = 5; i < 8; i++) chk($sformatf("dc_y%0d", i), cap_at(i), 95619);

    // DC full scale: saturates or wraps depending on build.
    do_reset();
    cap_q.delete();
    for (int s = 0; s < 32; s++) send(18'sd131071, b);
    repeat (16) begin @(posedge clk); #1; end
    chk("dcmax_count", cap_q.size(), 8);
    for (int i = 5; i < 8; i++) chk($sformatf("dcmax_y%0d", i), cap_at(i), DC_MAX_Y);

    // Back-to-back samples: second trigger lands while busy.
    do_reset();
    phase_sel = 2'd0;
    x_in = 18'sd65536; in_valid = 1'b1;
    @(posedge clk); #1;
    x_in = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("ovr_before", overrun, 0);
    @(posedge clk); #1;
    chk("ovr_set", overrun, 1);
    repeat (9) begin @(posedge clk); #1; end
    chk("ovr_yv_t13", y_valid, 1);
    chk("ovr_y_t13", y, 549);
    repeat (6) begin @(posedge clk); #1; end
    chk("ovr_busy_again", busy, 1);
    chk("ovr_sticky", overrun, 1);

    // Asynchronous reset in the middle of a MAC sequence.
    #2 reset = 1'b0;
    #1;
    chk("midrst_y", y, 0);
    chk("midrst_y_valid", y_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    phase_sel = 2'd2;
    send(18'sd0, b);
    chk("ph2_s0_busy", b, 0);
    send(18'sd0, b);
    chk("ph2_s1_busy", b, 0);
    send(18'sd0, b);
    chk("ph2_s2_busy", b, 1);
    repeat (20) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
